// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared SPI types and frame-geometry defaults
package spi_pkg;

  // SPI mode encoding {CPOL, CPHA}; both ends of the link run mode 0
  localparam logic [1:0] SPI_MODE0 = 2'b00;

  // Frame geometry shared by master and slave so one CS window lines up on both ends
  localparam int SPI_F_SIZE = 8;
  localparam int SPI_F_NUM  = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    DONE    = 2'd2
  } spi_slave_state_t;

endpackage

// File: rtl/spi_tx_mux.sv
// rtl/spi_tx_mux.sv - negedge transmit index and MISO bit select
module spi_tx_mux #(
  parameter int TOTAL = 8,
  parameter int TX_W  = $clog2(TOTAL + 1)
) (
  input  logic             SCLK,
  input  logic             rst,
  input  logic             CS,
  input  logic [TOTAL-1:0] tx_data_i,
  output logic             MISO
);

  logic [TX_W-1:0] tx_idx;
  logic            miso_bit;

  // Advance to the next payload bit on each falling edge; parks at TOTAL once the payload is spent
  always_ff @(negedge SCLK or posedge rst or posedge CS) begin
    if (rst || CS) begin
      tx_idx <= '0;
    end else if (tx_idx < TX_W'(TOTAL)) begin
      tx_idx <= tx_idx + 1'b1;
    end
  end

  // Select payload bit TOTAL-1-tx_idx; no match once tx_idx reaches TOTAL, so the line reads 0
  always_comb begin
    miso_bit = 1'b0;
    for (int i = 0; i < TOTAL; i++) begin
      if (tx_idx == TX_W'(TOTAL - 1 - i)) begin
        miso_bit = tx_data_i[i];
      end
    end
  end

  assign MISO = !CS && !rst && miso_bit;

endmodule

// File: rtl/spi_fsm_slave.sv
// rtl/spi_fsm_slave.sv - SPI mode-0 responder clocked only by SCLK and CS
module spi_fsm_slave
  import spi_pkg::*;
#(
  parameter int F_NUM   = SPI_F_NUM,
  parameter int F_SIZE  = SPI_F_SIZE,
  parameter int TOTAL   = F_NUM * F_SIZE,
  parameter int C_SIZE  = $clog2(F_SIZE + 1),
  parameter int FC_SIZE = $clog2(F_NUM + 1),
  parameter int TX_W    = $clog2(TOTAL + 1)
) (
  input  logic               SCLK,
  input  logic               rst,
  input  logic               CS,
  input  logic               MOSI,
  input  logic [TOTAL-1:0]   tx_data_i,
  output logic               MISO,
  output logic [F_SIZE-1:0]  rx_data_o,
  output logic [FC_SIZE-1:0] rx_frame_o,
  output logic               rx_valid_o,
  output logic               rx_done_o,
  output logic               ovr_o,
  output logic [1:0]         state_d
);

  spi_slave_state_t   state, state_nxt;
  logic [C_SIZE-1:0]  bit_cnt, bit_cnt_nxt;
  logic [FC_SIZE-1:0] f_cnt, f_cnt_nxt;
  // Only F_SIZE-1 history bits are kept; the frame's last bit comes straight from MOSI
  logic [F_SIZE-2:0]  rx_shift, rx_shift_nxt;
  logic [F_SIZE-1:0]  rx_word;
  logic               frame_done;
  logic               last_frame;
  logic               start;
  logic               ovr_set;
  logic               blocked;

  assign rx_word = {rx_shift, MOSI};
  assign state_d = state;

  // A reset landing inside a CS window locks reception out until the master closes that window
  always_ff @(posedge rst or posedge CS) begin
    if (CS) begin
      blocked <= 1'b0;
    end else begin
      blocked <= 1'b1;
    end
  end

  // State, counters and shift register live only for the current CS window
  always_ff @(posedge SCLK or posedge rst or posedge CS) begin
    if (rst || CS) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      f_cnt      <= '0;
      rx_shift   <= '0;
      rx_valid_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      bit_cnt    <= bit_cnt_nxt;
      f_cnt      <= f_cnt_nxt;
      rx_shift   <= rx_shift_nxt;
      rx_valid_o <= frame_done;
    end
  end

  // Next state plus the per-edge receive decisions (sample, frame completion, overrun)
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    f_cnt_nxt    = f_cnt;
    rx_shift_nxt = rx_shift;
    frame_done   = 1'b0;
    last_frame   = 1'b0;
    start        = 1'b0;
    ovr_set      = 1'b0;
    case (state)
      IDLE, RECEIVE: begin
        if (state == RECEIVE || !blocked) begin
          start        = (state == IDLE);
          rx_shift_nxt = rx_word[F_SIZE-2:0];
          if (bit_cnt == C_SIZE'(F_SIZE - 1)) begin
            bit_cnt_nxt = '0;
            frame_done  = 1'b1;
            f_cnt_nxt   = f_cnt + 1'b1;
            last_frame  = (f_cnt == FC_SIZE'(F_NUM - 1));
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
          state_nxt = last_frame ? DONE : RECEIVE;
        end
      end
      DONE: begin
        ovr_set = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Received data and status flags survive CS high so the host can read them after the window
  always_ff @(posedge SCLK or posedge rst) begin
    if (rst) begin
      rx_data_o  <= '0;
      rx_frame_o <= '0;
      rx_done_o  <= 1'b0;
      ovr_o      <= 1'b0;
    end else if (!CS) begin
      if (start) begin
        rx_done_o <= 1'b0;
        ovr_o     <= 1'b0;
      end
      if (frame_done) begin
        rx_data_o  <= rx_word;
        rx_frame_o <= f_cnt;
      end
      if (last_frame) begin
        rx_done_o <= 1'b1;
      end
      if (ovr_set) begin
        ovr_o <= 1'b1;
      end
    end
  end

  spi_tx_mux #(
    .TOTAL (TOTAL),
    .TX_W  (TX_W)
  ) u_tx_mux (
    .SCLK      (SCLK),
    .rst       (rst),
    .CS        (CS),
    .tx_data_i (tx_data_i),
    .MISO      (MISO)
  );

endmodule

// File: tb/tb_spi_fsm_slave.sv
// tb/tb_spi_fsm_slave.sv - directed bench for spi_fsm_slave
module tb_spi_fsm_slave;

  logic        SCLK;
  logic        rst;
  logic        cs1, cs2;
  logic        mosi;
  logic [7:0]  tx1;
  logic [15:0] tx2;

  logic        miso1, miso2;
  logic [7:0]  rx_data1, rx_data2;
  logic        rx_frame1;
  logic [1:0]  rx_frame2;
  logic        valid1, valid2, done1, done2, ovr1, ovr2;
  logic [1:0]  st1, st2;

  logic        smp1, smp2;
  int          checks;
  int          errors;

  spi_fsm_slave #(.F_NUM(1), .F_SIZE(8)) dut1 (
    .SCLK(SCLK), .rst(rst), .CS(cs1), .MOSI(mosi), .tx_data_i(tx1),
    .MISO(miso1), .rx_data_o(rx_data1), .rx_frame_o(rx_frame1),
    .rx_valid_o(valid1), .rx_done_o(done1), .ovr_o(ovr1), .state_d(st1)
  );

  spi_fsm_slave #(.F_NUM(2), .F_SIZE(8)) dut2 (
    .SCLK(SCLK), .rst(rst), .CS(cs2), .MOSI(mosi), .tx_data_i(tx2),
    .MISO(miso2), .rx_data_o(rx_data2), .rx_frame_o(rx_frame2),
    .rx_valid_o(valid2), .rx_done_o(done2), .ovr_o(ovr2), .state_d(st2)
  );

  // Drive MOSI, capture MISO as the master would, then raise SCLK
  task automatic pos(input logic b);
    mosi = b;
    #2;
    smp1 = miso1;
    smp2 = miso2;
    #3 SCLK = 1'b1;
    #1;
  endtask

  task automatic neg();
    #4 SCLK = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cs1 = 1'b1; cs2 = 1'b1; SCLK = 1'b0; mosi = 1'b0;
    tx1 = 8'h00; tx2 = 16'h0000;
    #10;
    rst = 1'b0;
    #5;
    checks++; if (miso1 !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", miso1); end
    checks++; if (rx_data1 !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data1); end
    checks++; if (rx_frame1 !== 1'b0) begin errors++; $display("FAIL reset_rx_frame got %b exp 0", rx_frame1); end
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done1); end
    checks++; if (ovr1 !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", ovr1); end
    checks++; if (st1 !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", st1); end
  endtask

  task automatic test_single_frame();
    logic [7:0] rx_v;
    logic [7:0] tx_v;
    rx_v = 8'hA5;
    tx_v = 8'h3C;
    tx1 = tx_v;
    cs1 = 1'b0;
    #1;
    checks++; if (miso1 !== 1'b0) begin errors++; $display("FAIL miso_first_bit got %b exp 0", miso1); end
    for (int i = 0; i < 8; i++) begin
      pos(rx_v[7-i]);
      checks++; if (smp1 !== tx_v[7-i]) begin errors++; $display("FAIL miso_bit%0d got %b exp %b", i, smp1, tx_v[7-i]); end
      if (i == 6) begin
        checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL valid_early got %b exp 0", valid1); end
      end
      if (i < 7) neg();
    end
    checks++; if (rx_data1 !== 8'hA5) begin errors++; $display("FAIL single_rx_data got %h exp a5", rx_data1); end
    checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", valid1); end
    checks++; if (rx_frame1 !== 1'b0) begin errors++; $display("FAIL single_frame got %b exp 0", rx_frame1); end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL single_done got %b exp 1", done1); end
    checks++; if (st1 !== 2'd2) begin errors++; $display("FAIL single_state got %0d exp 2", st1); end
    neg();
    checks++; if (miso1 !== 1'b0) begin errors++; $display("FAIL miso_spent got %b exp 0", miso1); end
  endtask

  task automatic test_overrun();
    pos(1'b1);
    checks++; if (ovr1 !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", ovr1); end
    checks++; if (st1 !== 2'd2) begin errors++; $display("FAIL ovr_state got %0d exp 2", st1); end
    checks++; if (rx_data1 !== 8'hA5) begin errors++; $display("FAIL ovr_rx_data got %h exp a5", rx_data1); end
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL ovr_valid got %b exp 0", valid1); end
    neg();
    cs1 = 1'b1;
    #2;
    checks++; if (miso1 !== 1'b0) begin errors++; $display("FAIL cs_high_miso got %b exp 0", miso1); end
    checks++; if (st1 !== 2'd0) begin errors++; $display("FAIL cs_high_state got %0d exp 0", st1); end
    checks++; if (ovr1 !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", ovr1); end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL done_sticky got %b exp 1", done1); end
  endtask

  task automatic test_abort();
    logic [7:0] v;
    cs1 = 1'b0;
    #3;
    for (int i = 0; i < 5; i++) begin
      pos(1'b1);
      if (i == 0) begin
        checks++; if (ovr1 !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", ovr1); end
        checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL done_clear got %b exp 0", done1); end
      end
      neg();
    end
    cs1 = 1'b1;
    #2;
    checks++; if (rx_data1 !== 8'hA5) begin errors++; $display("FAIL abort_rx_data got %h exp a5", rx_data1); end
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL abort_valid got %b exp 0", valid1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", done1); end
    v = 8'h5A;
    cs1 = 1'b0;
    #3;
    for (int i = 0; i < 8; i++) begin
      pos(v[7-i]);
      if (i < 7) neg();
    end
    checks++; if (rx_data1 !== 8'h5A) begin errors++; $display("FAIL after_abort_rx_data got %h exp 5a", rx_data1); end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL after_abort_done got %b exp 1", done1); end
    neg();
    cs1 = 1'b1;
    #2;
  endtask

  task automatic test_two_frames();
    logic [15:0] v;
    logic [15:0] got;
    v = 16'h1234;
    tx2 = 16'hBEEF;
    got = 16'h0000;
    cs2 = 1'b0;
    #3;
    for (int i = 0; i < 16; i++) begin
      pos(v[15-i]);
      got = {got[14:0], smp2};
      if (i == 7) begin
        checks++; if (rx_data2 !== 8'h12) begin errors++; $display("FAIL f0_rx_data got %h exp 12", rx_data2); end
        checks++; if (rx_frame2 !== 2'd0) begin errors++; $display("FAIL f0_frame got %0d exp 0", rx_frame2); end
        checks++; if (valid2 !== 1'b1) begin errors++; $display("FAIL f0_valid got %b exp 1", valid2); end
        checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL f0_done got %b exp 0", done2); end
        checks++; if (st2 !== 2'd1) begin errors++; $display("FAIL f0_state got %0d exp 1", st2); end
      end
      if (i == 8) begin
        checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL f0_valid_drop got %b exp 0", valid2); end
      end
      if (i < 15) neg();
    end
    checks++; if (rx_data2 !== 8'h34) begin errors++; $display("FAIL f1_rx_data got %h exp 34", rx_data2); end
    checks++; if (rx_frame2 !== 2'd1) begin errors++; $display("FAIL f1_frame got %0d exp 1", rx_frame2); end
    checks++; if (valid2 !== 1'b1) begin errors++; $display("FAIL f1_valid got %b exp 1", valid2); end
    checks++; if (done2 !== 1'b1) begin errors++; $display("FAIL f1_done got %b exp 1", done2); end
    checks++; if (st2 !== 2'd2) begin errors++; $display("FAIL f1_state got %0d exp 2", st2); end
    checks++; if (got !== 16'hBEEF) begin errors++; $display("FAIL f2_miso_stream got %h exp beef", got); end
    neg();
    cs2 = 1'b1;
    #2;
    checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL f1_valid_cs got %b exp 0", valid2); end
  endtask

  task automatic test_rst_mid();
    logic [7:0] v;
    tx1 = 8'hFF;
    cs1 = 1'b0;
    #3;
    for (int i = 0; i < 4; i++) begin
      pos(1'b1);
      if (i < 3) neg();
    end
    rst = 1'b1;
    #1;
    checks++; if (miso1 !== 1'b0) begin errors++; $display("FAIL rst_miso got %b exp 0", miso1); end
    checks++; if (rx_data1 !== 8'h00) begin errors++; $display("FAIL rst_rx_data got %h exp 00", rx_data1); end
    checks++; if (rx_frame1 !== 1'b0) begin errors++; $display("FAIL rst_frame got %b exp 0", rx_frame1); end
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done1); end
    checks++; if (ovr1 !== 1'b0) begin errors++; $display("FAIL rst_ovr got %b exp 0", ovr1); end
    checks++; if (st1 !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", st1); end
    #2;
    rst = 1'b0;
    neg();
    for (int i = 0; i < 8; i++) begin
      pos(1'b1);
      neg();
    end
    checks++; if (st1 !== 2'd0) begin errors++; $display("FAIL locked_state got %0d exp 0", st1); end
    checks++; if (rx_data1 !== 8'h00) begin errors++; $display("FAIL locked_rx_data got %h exp 00", rx_data1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL locked_done got %b exp 0", done1); end
    cs1 = 1'b1;
    #3;
    v = 8'hC3;
    cs1 = 1'b0;
    #3;
    for (int i = 0; i < 8; i++) begin
      pos(v[7-i]);
      if (i < 7) neg();
    end
    checks++; if (rx_data1 !== 8'hC3) begin errors++; $display("FAIL restart_rx_data got %h exp c3", rx_data1); end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL restart_done got %b exp 1", done1); end
    neg();
    cs1 = 1'b1;
    #2;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    smp1 = 1'b0;
    smp2 = 1'b0;
    test_reset();
    test_single_frame();
    test_overrun();
    test_abort();
    test_two_frames();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
